// File: rtl/vm_dispenser.sv
// Vending dispenser: queues vend/change requests in a 4-entry FIFO and
// sequences the product motor and the coin ejector from a small FSM.
module vm_dispenser #(
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned COIN_ON      = 2,
    parameter int unsigned COIN_GAP     = 2,
    parameter int unsigned COIN_MAX     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       purchase,
    input  logic [1:0] cash_return,
    input  logic       refill,
    output logic       motor_on,
    output logic       coin_eject,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       no_change,
    output logic [3:0] coin_count
);

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = 2;
    localparam int unsigned OCC_W    = 3;
    localparam int unsigned INV_W    = 4;
    localparam int unsigned PH_MAX_A = (MOTOR_CYCLES > COIN_ON) ? MOTOR_CYCLES : COIN_ON;
    localparam int unsigned PH_MAX   = (PH_MAX_A > COIN_GAP) ? PH_MAX_A : COIN_GAP;
    localparam int unsigned PH_W     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOTOR   = 2'd1,
        COIN_HI = 2'd2,
        COIN_LO = 2'd3
    } state_t;

    typedef struct packed {
        logic       purchase;
        logic [1:0] coins;
    } entry_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [1:0]         coins_left_q, coins_left_d;
    logic [1:0]         coins_src;
    logic               want_coin;
    logic               take_coin;
    logic               short_coin;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   q_cnt, q_cnt_d;
    entry_t             entry_in;
    entry_t             head;
    logic [1:0]         req_coins;
    logic               push, pop, accept, drop;

    logic               motor_on_d, coin_eject_d, busy_d, fifo_full_d;
    logic               overflow_d, no_change_d;
    logic [INV_W-1:0]   coin_count_d;

    // Request decode and queue bookkeeping
    always_comb begin
        req_coins = 2'd0;
        if (cash_return == 2'b01) begin
            req_coins = 2'd1;
        end else if (cash_return == 2'b10) begin
            req_coins = 2'd2;
        end
        entry_in = '{purchase: purchase, coins: req_coins};
        push     = purchase || (req_coins != 2'd0);
        head     = mem[rd_ptr];
        pop      = (state_q == IDLE) && (q_cnt != OCC_W'(0));
        accept   = push && ((q_cnt != OCC_W'(DEPTH)) || pop);
        drop     = push && !accept;
        q_cnt_d  = q_cnt;
        case ({accept, pop})
            2'b10:   q_cnt_d = q_cnt + OCC_W'(1);
            2'b01:   q_cnt_d = q_cnt - OCC_W'(1);
            default: q_cnt_d = q_cnt;
        endcase
    end

    // Next-state logic, phase counter and coin bookkeeping
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        coins_left_d = coins_left_q;
        coins_src    = coins_left_q;
        want_coin    = 1'b0;
        take_coin    = 1'b0;
        short_coin   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    coins_src    = head.coins;
                    coins_left_d = head.coins;
                    if (head.purchase) begin
                        state_d = MOTOR;
                        ph_d    = '0;
                    end else if (head.coins != 2'd0) begin
                        want_coin = 1'b1;
                    end
                end
            end
            MOTOR: begin
                if (ph_q == PH_W'(MOTOR_CYCLES - 1)) begin
                    if (coins_left_q != 2'd0) begin
                        want_coin = 1'b1;
                    end else begin
                        state_d = IDLE;
                        ph_d    = '0;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            COIN_HI: begin
                if (ph_q == PH_W'(COIN_ON - 1)) begin
                    state_d = COIN_LO;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            COIN_LO: begin
                if (ph_q == PH_W'(COIN_GAP - 1)) begin
                    if (coins_left_q != 2'd0) begin
                        want_coin = 1'b1;
                    end else begin
                        state_d = IDLE;
                        ph_d    = '0;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Entering COIN_HI only happens with a coin in stock; otherwise flag it.
        if (want_coin) begin
            ph_d = '0;
            if (coin_count != INV_W'(0)) begin
                state_d      = COIN_HI;
                coins_left_d = coins_src - 2'd1;
                take_coin    = 1'b1;
            end else begin
                state_d      = IDLE;
                coins_left_d = 2'd0;
                short_coin   = 1'b1;
            end
        end
    end

    // Next values of the registered outputs
    always_comb begin
        motor_on_d   = (state_d == MOTOR);
        coin_eject_d = (state_d == COIN_HI);
        busy_d       = (state_d != IDLE) || (q_cnt_d != OCC_W'(0));
        fifo_full_d  = (q_cnt_d == OCC_W'(DEPTH));
        overflow_d   = overflow || drop;
        no_change_d  = no_change || short_coin;
        coin_count_d = coin_count;
        if (refill) begin
            coin_count_d = INV_W'(COIN_MAX);
        end else if (take_coin) begin
            coin_count_d = coin_count - INV_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, queue pointers and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q         <= '0;
            coins_left_q <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            motor_on     <= 1'b0;
            coin_eject   <= 1'b0;
            busy         <= 1'b0;
            fifo_full    <= 1'b0;
            overflow     <= 1'b0;
            no_change    <= 1'b0;
            coin_count   <= INV_W'(COIN_MAX);
        end else begin
            ph_q         <= ph_d;
            coins_left_q <= coins_left_d;
            q_cnt        <= q_cnt_d;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            motor_on     <= motor_on_d;
            coin_eject   <= coin_eject_d;
            busy         <= busy_d;
            fifo_full    <= fifo_full_d;
            overflow     <= overflow_d;
            no_change    <= no_change_d;
            coin_count   <= coin_count_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= entry_in;
        end
    end

endmodule

// File: doc/vm_dispenser.md
VM_DISPENSER -- requirements
Module: vm_dispenser

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- MOTOR_CYCLES, 8, product motor on-time in clocks.
- COIN_ON, 2, coin ejector pulse width in clocks.
- COIN_GAP, 2, low clocks after each coin pulse.
- COIN_MAX, 15, coin inventory after refill (fits 4 bits).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, the single clock; all logic on its rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- purchase, in, 1, vend request, sampled every clock.
- cash_return, in, 2, change request: 00 none, 01 one coin, 10 two coins, 11 reserved (treated as 00).
- refill, in, 1, reload coin inventory.
- motor_on, out, 1, product motor drive.
- coin_eject, out, 1, coin ejector drive.
- busy, out, 1, FSM not IDLE or queue non-empty.
- fifo_full, out, 1, request queue holds 4 entries.
- overflow, out, 1, sticky: a request was dropped.
- no_change, out, 1, sticky: a coin was owed with inventory 0.
- coin_count, out, 4, current coin inventory.

Function
REQ-003 A request SHALL be any clock with purchase=1 or cash_return in {01,10}; it enqueues one entry {purchase, coins}, with coins taken from cash_return; purchase and coins arriving in the same clock SHALL form one entry.
REQ-004 The request queue SHALL be a 4-entry FIFO with wrapping 2-bit pointers and a 3-bit occupancy count; fifo_full SHALL equal (count==4).
REQ-005 On an enqueue when full with no pop in the same clock, the entry SHALL be dropped and overflow set; on a simultaneous pop and enqueue when full, the entry SHALL be accepted.
REQ-006 The FSM states SHALL be IDLE, MOTOR, COIN_HI, COIN_LO, with a per-entry coins_left register (2 bits).
REQ-007 In IDLE with the queue non-empty, the FSM SHALL pop the head entry and go to:
- MOTOR if its purchase bit is 1;
- otherwise COIN_HI if coins>0.
REQ-008 MOTOR SHALL last exactly MOTOR_CYCLES clocks with motor_on=1, then go to COIN_HI if coins_left>0, else IDLE.
REQ-009 On entering COIN_HI with coin_count>0, coin_count SHALL decrement by 1 and coins_left by 1.
REQ-010 On entering COIN_HI with coin_count=0, no_change SHALL be set, coins_left SHALL be cleared, coin_eject SHALL stay 0, and the FSM SHALL go to IDLE.
REQ-011 COIN_HI SHALL hold coin_eject=1 for COIN_ON clocks, then COIN_LO SHALL hold coin_eject=0 for COIN_GAP clocks, then return to COIN_HI if coins_left>0, else IDLE.
REQ-012 Latency: for a request sampled at edge t into an empty queue with the FSM in IDLE, motor_on (or coin_eject for a change-only entry) SHALL first be 1 after edge t+1.
REQ-013 motor_on and coin_eject SHALL be registered outputs and never be 1 in the same clock.
REQ-014 refill=1 SHALL set coin_count to COIN_MAX at the next edge, taking priority over a simultaneous decrement; refill SHALL not clear no_change.
REQ-015 busy SHALL be 1 whenever the state is not IDLE or the queue count is greater than 0.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously force the following, independent of clk:
- state=IDLE; queue empty with both pointers 0;
- motor_on, coin_eject, busy, fifo_full, overflow, no_change = 0;
- coin_count=COIN_MAX.
REQ-017 Reset asserted mid-dispense SHALL abort the cycle immediately (outputs 0 within the same clock) and discard all queued entries.
REQ-018 The first request SHALL be sampled at the first rising edge at which rst_n=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single purchase=1, cash_return=00 -> motor_on high for 8 clocks starting after edge t+1; coin_count stays 15; busy falls the clock after.
- purchase=1 with cash_return=10 in one clock -> 8 motor clocks, then two coin_eject pulses of 2 clocks each separated by 2 low clocks; coin_count 15->13.
- 6 back-to-back change requests (01) while busy -> fifo_full=1, overflow=1, exactly 5 coins ejected (one in service plus 4 queued).
- Inventory 0 and request cash_return=01 -> no coin_eject, no_change=1, FSM back to IDLE; a following refill sets coin_count=15 and no_change stays 1.
- rst_n pulsed low during the 4th motor clock with 2 entries queued -> motor_on=0 at once, busy=0, coin_count=15, no further activity.
- refill in the same clock as a COIN_HI entry -> coin_count=15, not 14.
